// File: rtl/apu_uart_pkg.sv
// Shared types and constants for the APU serial register loader.
package apu_uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic {
        DEC_EMPTY,
        DEC_HELD
    } dec_state_t;

    localparam int CMD_FLAG_BIT = 7;
    localparam int ADDR_LSB     = 1;
    localparam int DATA_MSB_BIT = 0;

    function automatic int bit_clks(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/apu_uart_loader_rx.sv
// 8N1 UART receiver: rx synchroniser, start-bit validation, framing check.
module uart_rx
    import apu_uart_pkg::*;
#(
    parameter int BIT_CLKS = 186
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);
    localparam int CW     = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int HALF_I = (BIT_CLKS / 2 > 0) ? BIT_CLKS / 2 - 1 : 0;
    localparam logic [CW-1:0] FULL = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF = CW'(HALF_I);

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            vld_n, ferr_n;

    assign rx_byte = shreg;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        vld_n     = 1'b0;
        ferr_n    = 1'b0;
        if (!ena) begin
            state_n   = RX_IDLE;
            cnt_n     = '0;
            bit_idx_n = '0;
        end else begin
            unique case (state)
                RX_IDLE: if (rx_prev && !rx_sync) begin
                    state_n = RX_START;
                    cnt_n   = '0;
                end
                RX_START: if (cnt == HALF) begin
                    // Line back high at mid start bit means a glitch, not a frame
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? RX_IDLE : RX_DATA;
                end else cnt_n = cnt + 1'b1;
                RX_DATA: if (cnt == FULL) begin
                    cnt_n   = '0;
                    shreg_n = {rx_sync, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else bit_idx_n = bit_idx + 1'b1;
                end else cnt_n = cnt + 1'b1;
                RX_STOP: if (cnt == FULL) begin
                    cnt_n = '0;
                    if (rx_sync) begin
                        vld_n   = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RX_WAIT_HIGH;
                    end
                end else cnt_n = cnt + 1'b1;
                RX_WAIT_HIGH: if (rx_sync) state_n = RX_IDLE;
                default: state_n = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            byte_vld  <= vld_n;
            frame_err <= ferr_n;
        end
    end

endmodule

// File: rtl/apu_uart_loader.sv
// Two-byte UART command decoder writing an APU register file.
// Optional CMD_TIMEOUT_EN drops a held data byte that waits too long for its address byte.
module apu_uart_loader
    import apu_uart_pkg::*;
#(
    parameter int CLK_HZ       = 1_789_773,
    parameter int BAUD         = 9600,
    parameter int ADDR_W       = 5,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       rx,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 wr_data,
    output logic [(2**ADDR_W)*8-1:0]   regs_flat,
    output logic                       frame_err,
    output logic                       cmd_err
);
    localparam int BIT_CLKS = bit_clks(CLK_HZ, BAUD);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [7:0]               rx_byte;
    logic                     byte_vld;
    dec_state_t               state, state_n;
    logic [6:0]               held, held_n;
    logic                     do_wr, err, to_exp;
    logic [5:0]               idx;
    logic [7:0]               wdata;
    logic [NUM_REGS-1:0][7:0] regs;

    uart_rx #(.BIT_CLKS(BIT_CLKS)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_vld  (byte_vld),
        .frame_err (frame_err)
    );

    assign idx       = rx_byte[6:ADDR_LSB];
    assign wdata     = {rx_byte[DATA_MSB_BIT], held};
    assign regs_flat = regs;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_CLKS = BIT_CLKS * TIMEOUT_BITS;
    localparam int TW      = $clog2(TO_CLKS + 1);
    logic [TW-1:0] to_cnt;

    assign to_exp = (state == DEC_HELD) && (to_cnt == TW'(TO_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt <= '0;
        else if (byte_vld || state != DEC_HELD || to_exp) to_cnt <= '0;
        else to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_exp = 1'b0;
`endif

    always_comb begin
        state_n = state;
        held_n  = held;
        do_wr   = 1'b0;
        err     = 1'b0;
        if (frame_err) begin
            state_n = DEC_EMPTY;
        end else if (byte_vld) begin
            if (!rx_byte[CMD_FLAG_BIT]) begin
                held_n  = rx_byte[6:0];
                state_n = DEC_HELD;
            end else begin
                state_n = DEC_EMPTY;
                if (state == DEC_HELD && {26'd0, idx} < 32'(NUM_REGS)) do_wr = 1'b1;
                else err = 1'b1;
            end
        end else if (to_exp) begin
            state_n = DEC_EMPTY;
            err     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DEC_EMPTY;
            held    <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            cmd_err <= 1'b0;
            regs    <= '0;
        end else begin
            state   <= state_n;
            held    <= held_n;
            wr_stb  <= do_wr;
            cmd_err <= err;
            if (do_wr) begin
                wr_addr                 <= idx[ADDR_W-1:0];
                wr_data                 <= wdata;
                regs[idx[ADDR_W-1:0]]   <= wdata;
            end
        end
    end

endmodule
